// File: rtl/speed_sensor.sv
// Wheel-pulse speed sensor: counts synchronized pulse edges over a fixed window and publishes a scaled, saturated speed.
// Define SPEED_SENSOR_AVG_EN to publish the 4-window moving average instead of the raw per-window value.
module speed_sensor #(
  parameter int WINDOW_CYCLES   = 1000,
  parameter int SPEED_PER_PULSE = 1,
  parameter int STALL_WINDOWS   = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       wheel_pulse,
  input  logic       enable,
  output logic [7:0] current_speed,
  output logic       speed_valid,
  output logic       stall
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [3:0] STALL_TH = 4'(STALL_WINDOWS);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic             sync_q1, sync_q2, sync_q3, tick;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       pulse_cnt;
  logic [3:0]       zero_cnt;

  logic [7:0]  pulse_total;
  logic [15:0] scaled;
  logic [7:0]  raw;
  logic [7:0]  speed_next;
  logic [3:0]  zero_next;
  logic        close;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_q1 <= wheel_pulse;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      tick    <= sync_q2 & ~sync_q3;
    end
  end

  // A tick arriving in the terminal cycle is folded into the closing window here.
  always_comb begin
    pulse_total = pulse_cnt;
    if (tick && (pulse_cnt != 8'hFF)) pulse_total = pulse_cnt + 8'd1;
    scaled    = 16'(pulse_total) * 16'(SPEED_PER_PULSE);
    raw       = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
    zero_next = 4'd0;
    if (pulse_total == 8'd0) zero_next = (zero_cnt == 4'hF) ? 4'hF : zero_cnt + 4'd1;
    close     = (state == COUNT) && enable && (win_cnt == WIN_LAST);
  end

`ifdef SPEED_SENSOR_AVG_EN
  // The newest history entry is raw itself, so only the three older ones are stored.
  logic [7:0] hist0, hist1, hist2;
  logic [9:0] avg_sum;

  always_comb begin
    avg_sum    = 10'(raw) + 10'(hist0) + 10'(hist1) + 10'(hist2);
    speed_next = avg_sum[9:2];
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      hist0 <= 8'd0;
      hist1 <= 8'd0;
      hist2 <= 8'd0;
    end else if (close) begin
      hist0 <= raw;
      hist1 <= hist0;
      hist2 <= hist1;
    end
  end
`else
  always_comb speed_next = raw;
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      win_cnt       <= '0;
      pulse_cnt     <= 8'd0;
      zero_cnt      <= 4'd0;
      current_speed <= 8'd0;
      speed_valid   <= 1'b0;
      stall         <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt   <= '0;
          pulse_cnt <= 8'd0;
          if (enable) state <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            state     <= IDLE;
            win_cnt   <= '0;
            pulse_cnt <= 8'd0;
          end else if (close) begin
            win_cnt       <= '0;
            pulse_cnt     <= 8'd0;
            zero_cnt      <= zero_next;
            current_speed <= speed_next;
            speed_valid   <= 1'b1;
            stall         <= (zero_next >= STALL_TH);
          end else begin
            win_cnt   <= win_cnt + 1'b1;
            pulse_cnt <= pulse_total;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_sensor.sv
// Scoreboard bench for speed_sensor: random pulse trains, enable aborts and resets against a window-level reference model.
module tb_speed_sensor;

  localparam int W       = 128;
  localparam int SPP     = 8;
  localparam int STALL_N = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       wheel_pulse = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] current_speed;
  logic       speed_valid;
  logic       stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int speed;
    int stall;
  } exp_t;

  exp_t exp_q[$];
  int   ticks[$];
  int   raw_hist[$];
  bit   run_active = 1'b0;
  int   run_start = 0;
  int   zero_windows = 0;
  bit   last_pin = 1'b0;
  bit   pin_lvl = 1'b0;
  int   pin_left = 0;
  int   held_speed = 0;
  int   held_stall = 0;

  speed_sensor #(
    .WINDOW_CYCLES(W),
    .SPEED_PER_PULSE(SPP),
    .STALL_WINDOWS(STALL_N)
  ) dut (
    .clk(clk),
    .clear(clear),
    .wheel_pulse(wheel_pulse),
    .enable(enable),
    .current_speed(current_speed),
    .speed_valid(speed_valid),
    .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Window [c-W+1, c] closes: count its ticks and derive the published values.
  task automatic closeWindow(input int c);
    int cnt;
    int raw;
    int spd;
    int sum;
    cnt = 0;
    sum = 0;
    foreach (ticks[i]) if (ticks[i] >= c - W + 1 && ticks[i] <= c) cnt++;
    while (ticks.size() > 0 && ticks[0] <= c) void'(ticks.pop_front());
    if (cnt > 255) cnt = 255;
    raw = cnt * SPP;
    if (raw > 255) raw = 255;
    if (cnt == 0) zero_windows = (zero_windows < 15) ? zero_windows + 1 : 15;
    else zero_windows = 0;
`ifdef SPEED_SENSOR_AVG_EN
    raw_hist.push_front(raw);
    if (raw_hist.size() > 4) void'(raw_hist.pop_back());
    foreach (raw_hist[i]) sum += raw_hist[i];
    spd = sum / 4;
`else
    spd = raw;
`endif
    exp_q.push_back('{c + 1, spd, (zero_windows >= STALL_N) ? 1 : 0});
  endtask

  // Drive one cycle's inputs at the falling edge and advance the reference model.
  task automatic step(input bit en, input bit clr, input bit pin);
    enable      = en;
    clear       = clr;
    wheel_pulse = pin;
    if (!clr) begin
      run_active   = 1'b0;
      zero_windows = 0;
      last_pin     = 1'b0;
      ticks.delete();
      raw_hist.delete();
      exp_q.delete();
    end else begin
      if (pin && !last_pin) ticks.push_back(cyc + 3);
      last_pin = pin;
      if (run_active && en && ((cyc - run_start) % W == W - 1)) closeWindow(cyc);
      if (en && !run_active) begin
        run_active = 1'b1;
        run_start  = cyc + 1;
      end else if (!en) begin
        run_active = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic genPin(input int mode, input int wmin, input int wmax, output bit p);
    if (pin_left > 0) pin_left--;
    else if (mode == 0) pin_lvl = 1'b0;
    else begin
      pin_lvl  = !pin_lvl;
      pin_left = int'($urandom_range(wmax, wmin)) - 1;
    end
    p = pin_lvl;
  endtask

  task automatic applyStimulus(input int n, input bit en, input int mode, input int wmin, input int wmax);
    bit p;
    for (int i = 0; i < n; i++) begin
      genPin(mode, wmin, wmax, p);
      step(en, 1'b1, p);
    end
  endtask

  task automatic applyReset(input int n);
    bit p;
    for (int i = 0; i < n; i++) begin
      genPin(1, 2, 3, p);
      step(1'b1, 1'b0, p);
    end
  endtask

  task automatic abortAtTerminal();
    bit p;
    for (int i = 0; i < 2 * W; i++) begin
      genPin(1, 2, 6, p);
      if (run_active && ((cyc - run_start) % W == W - 1)) begin
        step(1'b0, 1'b1, p);
        break;
      end
      step(1'b1, 1'b1, p);
    end
  endtask

  // Monitor: strobes must land exactly on scheduled cycles; outputs hold otherwise.
  always @(posedge clk) begin
    #2;
    if (!clear) begin
      checkOutput("reset_speed", int'(current_speed), 0);
      checkOutput("reset_valid", int'(speed_valid), 0);
      checkOutput("reset_stall", int'(stall), 0);
      held_speed = 0;
      held_stall = 0;
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("valid_strobe", int'(speed_valid), 1);
      checkOutput("speed", int'(current_speed), e.speed);
      checkOutput("stall", int'(stall), e.stall);
      held_speed = e.speed;
      held_stall = e.stall;
    end else begin
      checkOutput("no_strobe", int'(speed_valid), 0);
      checkOutput("held_speed", int'(current_speed), held_speed);
      checkOutput("held_stall", int'(stall), held_stall);
    end
  end

  initial begin
    #1 clear = 1'b0;
    @(negedge clk);
    applyReset(20);
    applyStimulus(4 * W, 1'b1, 1, 2, 8);
    applyStimulus(3 * W, 1'b1, 1, 2, 2);
    applyStimulus(5 * W, 1'b1, 0, 0, 0);
    applyStimulus(3 * W, 1'b1, 1, 40, 120);
    applyStimulus(50 + int'($urandom_range(30, 0)), 1'b1, 1, 2, 8);
    applyStimulus(40, 1'b0, 1, 2, 8);
    applyStimulus(2 * W + 10, 1'b1, 1, 2, 8);
    abortAtTerminal();
    applyStimulus(30, 1'b0, 0, 0, 0);
    applyStimulus(2 * W, 1'b1, 1, 3, 5);
    applyStimulus(70, 1'b1, 1, 2, 6);
    applyReset(6);
    applyStimulus(2 * W, 1'b1, 1, 2, 6);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(int'($urandom_range(3 * W, 20)), $urandom_range(9, 0) != 0,
                    int'($urandom_range(1, 0)), 2, int'($urandom_range(10, 2)));
    end
    applyStimulus(W + 10, 1'b0, 0, 0, 0);
    checkOutput("pending_expect", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
